// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel three-line-buffer scheduler.
package sobel_pkg;

   localparam int DEF_LINE_LEN    = 640;
   localparam int DEF_FRAME_LINES = 480;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      STREAM,
      EOL,
      FLUSH,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      PAD_NONE = 2'b00,
      PAD_TOP  = 2'b01,
      PAD_BOT  = 2'b10
   } pad_e;

   function automatic pad_e pad_for(input logic is_top, input logic is_bot);
      if (is_top)      return PAD_TOP;
      else if (is_bot) return PAD_BOT;
      else             return PAD_NONE;
   endfunction

endpackage

// File: rtl/mod3_counter.sv
// Wrap-around 0..2 counter selecting one of the three rotating line buffers.
module mod3_counter (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       adv_i,
   output logic [1:0] val_o
);

   logic [1:0] val_q, val_d;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      val_d = val_q;
      if (clr_i)      val_d = 2'd0;
      else if (adv_i) val_d = (val_q == 2'd2) ? 2'd0 : val_q + 2'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) val_q <= 2'd0;
      else       val_q <= val_d;
   end

   assign val_o = val_q;

endmodule

// File: rtl/sobel_line_sched.sv
// Frame scheduler for the Sobel line buffers: rotates writes over three RAMs and issues centre-line reads.
// Optional stall statistics are compiled in when SOBEL_LINE_SCHED_STATS_EN is defined.
module sobel_line_sched
   import sobel_pkg::*;
#(
   parameter int DATA_WD     = 8,
   parameter int ADDR_WD     = 10,
   parameter int LINE_LEN    = DEF_LINE_LEN,
   parameter int FRAME_LINES = DEF_FRAME_LINES,
   parameter int LINE_WD     = 9
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               pix_valid_i,
   input  logic [DATA_WD-1:0] pix_data_i,
   output logic               pix_ready_o,
   input  logic               out_ready_i,
   output logic               wr_en_o,
   output logic [1:0]         wr_buf_o,
   output logic [ADDR_WD-1:0] waddr_o,
   output logic [DATA_WD-1:0] wdata_o,
   output logic               r_en_o,
   output logic [ADDR_WD-1:0] raddr_o,
   output logic [1:0]         rd_center_o,
   output logic [1:0]         row_pad_o,
   output logic               frame_done_o,
   output logic [15:0]        stall_cnt_o
);

   localparam logic [ADDR_WD-1:0] LAST_COL  = ADDR_WD'(LINE_LEN - 1);
   localparam logic [LINE_WD-1:0] LAST_LINE = LINE_WD'(FRAME_LINES - 1);

   state_e             state_q, state_d;
   logic [ADDR_WD-1:0] col_q, col_d;
   logic [LINE_WD-1:0] line_q, line_d;
   logic [1:0]         wbuf, cbuf;
   logic               buf_clr, wbuf_adv, cbuf_adv;
   logic               accept, col_last;

   logic               wr_en_q, wr_en_d, r_en_q, r_en_d, done_q, done_d;
   logic [1:0]         wr_buf_q, wr_buf_d, rd_center_q, rd_center_d;
   logic [ADDR_WD-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
   logic [DATA_WD-1:0] wdata_q, wdata_d;
   pad_e               row_pad_q, row_pad_d;
   logic [LINE_WD-1:0] centre_line;

   mod3_counter u_wbuf (.clk_i(clk_i), .rst_i(rst_i), .clr_i(buf_clr), .adv_i(wbuf_adv), .val_o(wbuf));
   mod3_counter u_cbuf (.clk_i(clk_i), .rst_i(rst_i), .clr_i(buf_clr), .adv_i(cbuf_adv), .val_o(cbuf));

   assign pix_ready_o = (state_q == FILL) || ((state_q == STREAM) && out_ready_i);
   assign accept      = pix_valid_i && pix_ready_o;
   assign col_last    = (col_q == LAST_COL);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         col_q       <= '0;
         line_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_buf_q    <= 2'd0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         r_en_q      <= 1'b0;
         raddr_q     <= '0;
         rd_center_q <= 2'd0;
         row_pad_q   <= PAD_NONE;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         line_q      <= line_d;
         wr_en_q     <= wr_en_d;
         wr_buf_q    <= wr_buf_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         r_en_q      <= r_en_d;
         raddr_q     <= raddr_d;
         rd_center_q <= rd_center_d;
         row_pad_q   <= row_pad_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      line_d   = line_q;
      buf_clr  = 1'b0;
      wbuf_adv = 1'b0;
      cbuf_adv = 1'b0;
      unique case (state_q)
         IDLE: if (start_i) begin
            state_d = FILL;
            col_d   = '0;
            line_d  = '0;
            buf_clr = 1'b1;
         end
         FILL: if (accept) begin
            if (col_last) begin
               state_d  = STREAM;
               col_d    = '0;
               line_d   = LINE_WD'(1);
               wbuf_adv = 1'b1;
            end else col_d = col_q + ADDR_WD'(1);
         end
         STREAM: if (accept) begin
            if (col_last) state_d = EOL;
            else          col_d   = col_q + ADDR_WD'(1);
         end
         EOL: if (out_ready_i) begin
            col_d    = '0;
            cbuf_adv = 1'b1;
            if (line_q == LAST_LINE) state_d = FLUSH;
            else begin
               state_d  = STREAM;
               line_d   = line_q + LINE_WD'(1);
               wbuf_adv = 1'b1;
            end
         end
         FLUSH: if (out_ready_i) begin
            if (col_last) begin
               state_d = DONE;
               col_d   = '0;
            end else col_d = col_q + ADDR_WD'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Centre line trails the line being written by one; during FLUSH it is the last line.
   assign centre_line = (state_q == FLUSH) ? LAST_LINE : line_q - LINE_WD'(1);

   always_comb begin
      wr_en_d     = 1'b0;
      wr_buf_d    = wr_buf_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      r_en_d      = 1'b0;
      raddr_d     = raddr_q;
      rd_center_d = rd_center_q;
      row_pad_d   = PAD_NONE;
      done_d      = (state_q == DONE);
      if (accept) begin
         wr_en_d  = 1'b1;
         wr_buf_d = wbuf;
         waddr_d  = col_q;
         wdata_d  = pix_data_i;
      end
      unique case (state_q)
         STREAM: if (accept && (col_q != '0)) begin
            r_en_d  = 1'b1;
            raddr_d = col_q - ADDR_WD'(1);
         end
         EOL: if (out_ready_i) begin
            r_en_d  = 1'b1;
            raddr_d = LAST_COL;
         end
         FLUSH: if (out_ready_i) begin
            r_en_d  = 1'b1;
            raddr_d = col_q;
         end
         default: r_en_d = 1'b0;
      endcase
      if (r_en_d) begin
         rd_center_d = cbuf;
         row_pad_d   = pad_for(centre_line == '0, centre_line == LAST_LINE);
      end
   end

`ifdef SOBEL_LINE_SCHED_STATS_EN
   logic [15:0] stall_q;
   logic        stalled;

   assign stalled = !out_ready_i && ((state_q == STREAM) || (state_q == EOL) || (state_q == FLUSH));

   always_ff @(posedge clk_i) begin
      if (rst_i)                               stall_q <= '0;
      else if ((state_q == IDLE) && start_i)   stall_q <= '0;
      else if (stalled && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = 16'd0;
`endif

   assign wr_en_o      = wr_en_q;
   assign wr_buf_o     = wr_buf_q;
   assign waddr_o      = waddr_q;
   assign wdata_o      = wdata_q;
   assign r_en_o       = r_en_q;
   assign raddr_o      = raddr_q;
   assign rd_center_o  = rd_center_q;
   assign row_pad_o    = row_pad_q;
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_sobel_line_sched.sv
// Self-checking bench for sobel_line_sched: table vectors plus frame-level scoreboard runs.
module tb_sobel_line_sched;
   import sobel_pkg::*;

   localparam int DATA_WD     = 8;
   localparam int ADDR_WD     = 3;
   localparam int LINE_LEN    = 8;
   localparam int FRAME_LINES = 4;
   localparam int LINE_WD     = 2;
   localparam int NPIX        = LINE_LEN * FRAME_LINES;
   localparam int MAX_CYC     = 3000;

   logic               clk_i = 1'b0;
   logic               rst_i, start_i, pix_valid_i, out_ready_i;
   logic [DATA_WD-1:0] pix_data_i;
   logic               pix_ready_o, wr_en_o, r_en_o, frame_done_o;
   logic [1:0]         wr_buf_o, rd_center_o, row_pad_o;
   logic [ADDR_WD-1:0] waddr_o, raddr_o;
   logic [DATA_WD-1:0] wdata_o;
   logic [15:0]        stall_cnt_o;

   sobel_line_sched #(
      .DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD), .LINE_LEN(LINE_LEN),
      .FRAME_LINES(FRAME_LINES), .LINE_WD(LINE_WD)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pix_valid_i(pix_valid_i),
      .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o), .out_ready_i(out_ready_i),
      .wr_en_o(wr_en_o), .wr_buf_o(wr_buf_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
      .r_en_o(r_en_o), .raddr_o(raddr_o), .rd_center_o(rd_center_o), .row_pad_o(row_pad_o),
      .frame_done_o(frame_done_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]         bufn;
      logic [ADDR_WD-1:0] addr;
      logic [DATA_WD-1:0] data;
   } wr_t;

   typedef struct {
      logic [1:0]         ctr;
      logic [ADDR_WD-1:0] addr;
      logic [1:0]         pad;
   } rd_t;

   typedef struct {
      logic               start, valid, rdy;
      logic [DATA_WD-1:0] data;
      logic               exp_ready, exp_wr, exp_rd;
      logic [ADDR_WD-1:0] exp_waddr;
      logic [DATA_WD-1:0] exp_wdata;
   } vec_t;

   logic [DATA_WD-1:0] pix [NPIX];
   wr_t exp_w[$];
   rd_t exp_r[$];

   // Reference: line L goes to buffer L mod 3; every line is later read once as centre, in column order.
   task automatic build_model();
      logic [1:0] pad;
      exp_w.delete();
      exp_r.delete();
      for (int l = 0; l < FRAME_LINES; l++) begin
         for (int c = 0; c < LINE_LEN; c++) begin
            pix[l*LINE_LEN+c] = DATA_WD'($urandom);
            exp_w.push_back('{bufn: 2'(l % 3), addr: ADDR_WD'(c), data: pix[l*LINE_LEN+c]});
         end
      end
      for (int l = 0; l < FRAME_LINES; l++) begin
         pad = (l == 0) ? PAD_TOP : (l == FRAME_LINES - 1) ? PAD_BOT : PAD_NONE;
         for (int c = 0; c < LINE_LEN; c++)
            exp_r.push_back('{ctr: 2'(l % 3), addr: ADDR_WD'(c), pad: pad});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, wr_en_o, 0);
      check({tag, "_wr_buf"}, wr_buf_o, 0);
      check({tag, "_waddr"}, waddr_o, 0);
      check({tag, "_wdata"}, wdata_o, 0);
      check({tag, "_r_en"}, r_en_o, 0);
      check({tag, "_raddr"}, raddr_o, 0);
      check({tag, "_rd_center"}, rd_center_o, 0);
      check({tag, "_row_pad"}, row_pad_o, 0);
      check({tag, "_frame_done"}, frame_done_o, 0);
      check({tag, "_stall_cnt"}, stall_cnt_o, 0);
      check({tag, "_pix_ready"}, pix_ready_o, 0);
   endtask

   // rdy_mode: 0 always ready, 1 random, 2 five-cycle stall mid-STREAM.
   task automatic run_frame(input int rdy_mode, input int start_at, input int abort_after);
      int  idx = 0, cyc = 0, done_cyc = -1, done_cnt = 0, nw = 0, nr = 0, win = 0;
      bit  win_used = 0;
      logic hs, quiet;
      wr_t ew;
      rd_t er;
      build_model();
      ew = exp_w[0];
      while (done_cyc < 0 && cyc < MAX_CYC) begin
         @(negedge clk_i);
         start_i     = (cyc == 0) || (cyc == start_at);
         pix_valid_i = (rdy_mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
         pix_data_i  = (idx < NPIX) ? pix[idx] : '1;
         if (rdy_mode == 2 && !win_used && nw == 12) begin
            win      = 5;
            win_used = 1'b1;
         end
         quiet = 1'b0;
         if (rdy_mode == 1) out_ready_i = 1'($urandom_range(1));
         else if (win > 0) begin
            out_ready_i = 1'b0;
            quiet       = 1'b1;
            win--;
         end else out_ready_i = 1'b1;
         #1;
         hs = pix_valid_i & pix_ready_o;
         if (quiet) check("stall_pix_ready", pix_ready_o, 0);
         @(posedge clk_i);
         #1;
         if (hs) idx++;
         if (wr_en_o) begin
            nw++;
            if (exp_w.size() == 0) check("extra_write", 1, 0);
            else begin
               ew = exp_w.pop_front();
               check("wr_buf", wr_buf_o, ew.bufn);
               check("waddr", waddr_o, ew.addr);
               check("wdata", wdata_o, ew.data);
            end
         end
         if (r_en_o) begin
            nr++;
            if (exp_r.size() == 0) check("extra_read", 1, 0);
            else begin
               er = exp_r.pop_front();
               check("rd_center", rd_center_o, er.ctr);
               check("raddr", raddr_o, er.addr);
               check("row_pad", row_pad_o, er.pad);
            end
         end else check("row_pad_unqualified", row_pad_o, PAD_NONE);
         if (wr_en_o && r_en_o) begin
            check("overlap_bufs_differ", wr_buf_o != rd_center_o, 1);
            check("overlap_raddr", raddr_o, ADDR_WD'(ew.addr - 1));
         end
         if (!out_ready_i) check("no_read_when_not_ready", r_en_o, 0);
         if (quiet) check("stall_no_write", wr_en_o, 0);
         if (frame_done_o) begin
            done_cnt++;
            done_cyc = cyc;
            check("writes_before_done", nw, NPIX);
            check("reads_before_done", nr, NPIX);
         end
         if (abort_after >= 0 && nw == abort_after + 1) begin
            @(negedge clk_i);
            rst_i   = 1'b1;
            start_i = 1'b0;
            @(posedge clk_i);
            #1;
            check_all_zero("abort");
            @(negedge clk_i);
            rst_i = 1'b0;
            repeat (3) begin
               @(posedge clk_i);
               #1;
               check("abort_no_done", frame_done_o, 0);
               check("abort_no_write", wr_en_o, 0);
               check("abort_no_read", r_en_o, 0);
            end
            return;
         end
         cyc++;
      end
      if (done_cyc < 0) check("frame_timeout", 1, 0);
      repeat (3) begin
         @(negedge clk_i);
         start_i     = 1'b0;
         pix_valid_i = 1'b1;
         out_ready_i = 1'b1;
         @(posedge clk_i);
         #1;
         if (frame_done_o) done_cnt++;
         check("idle_no_write", wr_en_o, 0);
         check("idle_no_read", r_en_o, 0);
      end
      check("done_pulses", done_cnt, 1);
      check("writes_left", exp_w.size(), 0);
      check("reads_left", exp_r.size(), 0);
      if (rdy_mode == 0) check("done_latency", done_cyc, 44);
`ifdef SOBEL_LINE_SCHED_STATS_EN
      if (rdy_mode == 2) check("stall_cnt", stall_cnt_o, 5);
`else
      if (rdy_mode == 2) check("stall_cnt", stall_cnt_o, 0);
`endif
      if (rdy_mode == 0) check("stall_cnt_zero", stall_cnt_o, 0);
   endtask

   vec_t vecs [6];

   initial begin
      rst_i       = 1'b1;
      start_i     = 1'b0;
      pix_valid_i = 1'b0;
      pix_data_i  = '0;
      out_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check_all_zero("reset");

      // start ignored-valid in IDLE, then FILL writes regardless of out_ready_i
      vecs[0] = '{start: 0, valid: 1, rdy: 1, data: 8'h11, exp_ready: 0, exp_wr: 0, exp_rd: 0, exp_waddr: 0, exp_wdata: 8'h00};
      vecs[1] = '{start: 1, valid: 1, rdy: 1, data: 8'h22, exp_ready: 0, exp_wr: 0, exp_rd: 0, exp_waddr: 0, exp_wdata: 8'h00};
      vecs[2] = '{start: 0, valid: 1, rdy: 0, data: 8'h33, exp_ready: 1, exp_wr: 1, exp_rd: 0, exp_waddr: 0, exp_wdata: 8'h33};
      vecs[3] = '{start: 0, valid: 0, rdy: 1, data: 8'h44, exp_ready: 1, exp_wr: 0, exp_rd: 0, exp_waddr: 0, exp_wdata: 8'h00};
      vecs[4] = '{start: 1, valid: 1, rdy: 1, data: 8'h55, exp_ready: 1, exp_wr: 1, exp_rd: 0, exp_waddr: 1, exp_wdata: 8'h55};
      vecs[5] = '{start: 0, valid: 1, rdy: 0, data: 8'h66, exp_ready: 1, exp_wr: 1, exp_rd: 0, exp_waddr: 2, exp_wdata: 8'h66};
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         start_i     = vecs[i].start;
         pix_valid_i = vecs[i].valid;
         pix_data_i  = vecs[i].data;
         out_ready_i = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d_pix_ready", i), pix_ready_o, vecs[i].exp_ready);
         @(posedge clk_i);
         #1;
         check($sformatf("vec%0d_wr_en", i), wr_en_o, vecs[i].exp_wr);
         check($sformatf("vec%0d_r_en", i), r_en_o, vecs[i].exp_rd);
         if (vecs[i].exp_wr) begin
            check($sformatf("vec%0d_waddr", i), waddr_o, vecs[i].exp_waddr);
            check($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp_wdata);
            check($sformatf("vec%0d_wr_buf", i), wr_buf_o, 0);
         end
      end

      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;

      run_frame(0, -1, -1);
      run_frame(0, 20, -1);
      run_frame(2, -1, -1);
      run_frame(1, -1, -1);
      run_frame(0, -1, 19);
      run_frame(0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
